// File: rtl/pe_weight_server.sv
// Weight buffer for one PE: filled through a valid/ready load stream, then serves
// one registered read per cycle. Reads hit only in SERVE and only below the loaded length.
module pe_weight_server #(
    parameter int D_W    = 64,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [D_W-1:0]    load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_done,
    input  logic [ADDR_W-1:0] weight_addr,
    output logic [D_W-1:0]    weight,
    output logic              weight_valid,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W:0] len_reg, wr_ptr, loaded_len;
    logic [D_W-1:0]  ram [DEPTH];
    logic            beat, last_beat, hit, start_ok;

    assign load_ready = (state == LOAD);
    assign busy       = (state == LOAD);
    assign beat       = load_ready && load_valid;
    assign last_beat  = beat && (wr_ptr == len_reg - ONE);
    assign start_ok   = load_start && (state != LOAD);
    // loaded_len never exceeds DEPTH, so addresses >= DEPTH always miss
    assign hit        = (state == SERVE) && ({1'b0, weight_addr} < loaded_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, SERVE: if (load_start) state_nxt = (load_len == '0) ? IDLE : LOAD;
            LOAD:        if (last_beat)  state_nxt = SERVE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            len_reg      <= '0;
            loaded_len   <= '0;
            load_done    <= 1'b0;
            weight       <= '0;
            weight_valid <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (start_ok) begin
                wr_ptr     <= '0;
                loaded_len <= '0;
                if (load_len == '0) load_done <= 1'b1;
                else                len_reg   <= (load_len > DEPTH_L) ? DEPTH_L : load_len;
            end
            if (beat) begin
                wr_ptr <= wr_ptr + ONE;
                if (last_beat) begin
                    loaded_len <= len_reg;
                    load_done  <= 1'b1;
                end
            end
            weight       <= hit ? ram[weight_addr[IDX_W-1:0]] : '0;
            weight_valid <= hit;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (beat) ram[wr_ptr[IDX_W-1:0]] <= load_data;
    end
endmodule

// File: tb/tb_pe_weight_server.sv
// Directed bench for pe_weight_server; read expectations come from a local
// buffer model and flow through a scoreboard queue.
module tb_pe_weight_server;
    localparam int D_W = 64, ADDR_W = 14, DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic [ADDR_W:0]   load_len = '0;
    logic [D_W-1:0]    load_data = '0;
    logic              load_valid = 1'b0;
    logic              load_ready, load_done, weight_valid, busy;
    logic [ADDR_W-1:0] weight_addr = '0;
    logic [D_W-1:0]    weight;

    pe_weight_server #(.D_W(D_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
        .load_done(load_done), .weight_addr(weight_addr), .weight(weight),
        .weight_valid(weight_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic v; logic [D_W-1:0] d; } rd_t;
    rd_t sb[$];
    logic [D_W-1:0] mdl [DEPTH];
    int  mdl_len = 0;
    bit  mdl_serve = 0;
    int  total = 0, bad = 0;

    task automatic chk(input string tag, input logic [D_W-1:0] obs, input logic [D_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_rd(input int a);
        rd_t e;
        e.v = mdl_serve && (a < mdl_len);
        e.d = e.v ? mdl[a] : '0;
        weight_addr = ADDR_W'(a);
        sb.push_back(e);
    endtask

    task automatic pop_rd(input string tag);
        rd_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, D_W'(weight_valid), D_W'(e.v));
            chk({tag, "_data"}, weight, e.d);
        end
    endtask

    task automatic rd(input int a, input string tag);
        push_rd(a);
        tick();
        pop_rd(tag);
    endtask

    task automatic start(input int len);
        load_start = 1'b1;
        load_len   = (ADDR_W+1)'(len);
        tick();
        load_start = 1'b0;
        mdl_serve  = 0;
        mdl_len    = 0;
    endtask

    initial begin
        // 1: reset state
        #12 rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            rd(0, "t1_rd");
            chk("t1_busy", D_W'(busy), 0);
            chk("t1_ready", D_W'(load_ready), 0);
        end

        // 2: four-word load, continuous valid
        start(4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_busy", D_W'(busy), 1);
            chk("t2_ready", D_W'(load_ready), 1);
            chk("t2_done_lo", D_W'(load_done), 0);
            load_valid = 1'b1;
            load_data  = D_W'((i + 1) * 'h11);
            mdl[i]     = load_data;
            tick();
        end
        load_valid = 1'b0;
        chk("t2_done", D_W'(load_done), 1);
        chk("t2_busy_end", D_W'(busy), 0);
        mdl_len = 4; mdl_serve = 1;
        for (int a = 0; a <= 4; a++) begin
            rd(a, "t2_rd");
            if (a == 0) chk("t2_done_pulse", D_W'(load_done), 0);
        end

        // 3: stalling stream
        start(3);
        begin
            automatic bit pat[5] = '{1, 0, 1, 0, 1};
            automatic int k = 0;
            for (int i = 0; i < 5; i++) begin
                load_valid = pat[i];
                load_data  = pat[i] ? D_W'(64'hC0DE_0000_0000_0000 + k) : D_W'(64'hDEAD);
                if (pat[i]) begin mdl[k] = load_data; k++; end
                tick();
                if (i == 3) chk("t3_done_early", D_W'(load_done), 0);
            end
        end
        load_valid = 1'b0;
        chk("t3_done", D_W'(load_done), 1);
        mdl_len = 3; mdl_serve = 1;
        for (int a = 0; a < 3; a++) rd(a, "t3_rd");

        // 4: oversize length clamps to DEPTH
        start(2000);
        load_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            load_data = D_W'(64'hA5A5_0000_0000_0000) | D_W'(i * 7 + 3);
            mdl[i]    = load_data;
            tick();
        end
        chk("t4_done", D_W'(load_done), 1);
        chk("t4_ready_off", D_W'(load_ready), 0);
        load_data = D_W'(64'hBAD);
        mdl_len = DEPTH; mdl_serve = 1;
        rd(DEPTH - 1, "t4_rd_last");
        chk("t4_ready_off2", D_W'(load_ready), 0);
        load_valid = 1'b0;
        rd(DEPTH, "t4_rd_over");
        rd(0, "t4_rd_first");

        // 5: async reset mid-load
        start(8);
        load_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            load_data = D_W'(64'h5500 + i);
            tick();
        end
        chk("t5_busy_pre", D_W'(busy), 1);
        rst = 1'b1;
        #1;
        chk("t5_busy", D_W'(busy), 0);
        chk("t5_ready", D_W'(load_ready), 0);
        chk("t5_done", D_W'(load_done), 0);
        chk("t5_wv", D_W'(weight_valid), 0);
        chk("t5_w", weight, 0);
        rst = 1'b0;
        load_valid = 1'b0;
        mdl_serve = 0; mdl_len = 0;
        rd(0, "t5_rd");

        // 6: reload from SERVE, restart ignored, then zero-length load
        start(2);
        load_valid = 1'b1;
        load_data = D_W'(1); mdl[0] = load_data; tick();
        load_data = D_W'(2); mdl[1] = load_data; tick();
        load_valid = 1'b0;
        mdl_len = 2; mdl_serve = 1;
        rd(1, "t6_rd_pre");
        push_rd(1);                 // read in the load_start cycle still hits
        load_start = 1'b1; load_len = (ADDR_W+1)'(1);
        tick();
        pop_rd("t6_rd_start");
        mdl_serve = 0; mdl_len = 0;
        load_len = (ADDR_W+1)'(5);  // ignored restart
        push_rd(0);
        tick();
        pop_rd("t6_rd_load0");
        chk("t6_busy", D_W'(busy), 1);
        load_start = 1'b0;
        load_valid = 1'b1; load_data = D_W'(64'hAB); mdl[0] = load_data;
        push_rd(0);
        tick();
        pop_rd("t6_rd_load1");
        load_valid = 1'b0;
        chk("t6_done", D_W'(load_done), 1);
        mdl_len = 1; mdl_serve = 1;
        rd(0, "t6_rd0");
        rd(1, "t6_rd1");

        start(0);
        chk("t6_zero_done", D_W'(load_done), 1);
        chk("t6_zero_busy", D_W'(busy), 0);
        rd(0, "t6_zero_rd");
        chk("t6_zero_done_lo", D_W'(load_done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
